// File: rtl/inv_key_schedule.sv
// inv_key_schedule: AES-128 decryption round-key generator, emits round keys 10 down to 0.
// Latency: start -> round-10 key valid 10 cycles later (1 cycle on a key-cache hit), then one key per transfer.
// Backpressure: rk/rk_round hold while rk_valid & !rk_ready; start is honoured only when idle.
// Optional feature: define KS_KEY_CACHE_EN to remember the last cipher key and its round-10 key.
module inv_key_schedule #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  input  logic          rk_ready,
  output logic [KW-1:0] rk,
  output logic [3:0]    rk_round,
  output logic          rk_valid,
  output logic          busy,
  output logic          done
);

  // AES S-box, entry x lives at bits [2047-8x -: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ctr;
  logic        xfer;
  logic        expand_last;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] inv_w3;
  logic [31:0] g_in;
  logic [3:0]  g_idx;
  logic [31:0] g_out;
  logic [31:0] f0, f1, f2, f3;
  logic [KW-1:0] fwd_rk;
  logic [KW-1:0] inv_rk;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

`ifdef KS_KEY_CACHE_EN
  logic          cache_vld;
  logic [KW-1:0] cache_key;
  logic [KW-1:0] cache_rk10;
  logic          cache_hit;
  assign cache_hit = cache_vld && (key_in == cache_key);
  // A cache hit enters EXPAND with ctr=0, which is a single pass-through cycle
  assign expand_last = (ctr == 4'(NR)) || (ctr == 4'd0);
`else
  assign expand_last = (ctr == 4'(NR));
`endif

  assign xfer = rk_valid & rk_ready;

  // Shared g()/S-box path: forward step during EXPAND, inverse step during OUT
  always_comb begin
    w0     = rk[127:96];
    w1     = rk[95:64];
    w2     = rk[63:32];
    w3     = rk[31:0];
    inv_w3 = w3 ^ w2;
    g_in   = (state == EXPAND) ? w3 : inv_w3;
    g_idx  = (state == EXPAND) ? ctr : rk_round;
    g_out  = sub_word({g_in[23:0], g_in[31:24]}) ^ {rcon(g_idx), 24'h000000};
    f0     = g_out ^ w0;
    f1     = f0 ^ w1;
    f2     = f1 ^ w2;
    f3     = f2 ^ w3;
    fwd_rk = {f0, f1, f2, f3};
    inv_rk = {w0 ^ g_out, w1 ^ w0, w2 ^ w1, inv_w3};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  if (expand_last) state_nxt = OUT;
      OUT:     if (xfer && (rk_round == 4'd0)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rk_valid = (state == OUT);
    busy     = (state != IDLE);
  end

  // Round-key register, round counters and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk       <= '0;
      rk_round <= 4'd0;
      ctr      <= 4'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef KS_KEY_CACHE_EN
            if (cache_hit) begin
              rk  <= cache_rk10;
              ctr <= 4'd0;
            end else
`endif
            begin
              rk  <= key_in;
              ctr <= 4'd1;
            end
          end
        end
        EXPAND: begin
`ifdef KS_KEY_CACHE_EN
          if (ctr == 4'd0) begin
            rk_round <= 4'(NR);
          end else
`endif
          begin
            rk  <= fwd_rk;
            ctr <= ctr + 4'd1;
            if (ctr == 4'(NR)) rk_round <= 4'(NR);
          end
        end
        OUT: begin
          if (xfer) begin
            if (rk_round != 4'd0) begin
              rk       <= inv_rk;
              rk_round <= rk_round - 4'd1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef KS_KEY_CACHE_EN
  // Key cache: invalidated when a new expansion starts, filled when it completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld  <= 1'b0;
      cache_key  <= '0;
      cache_rk10 <= '0;
    end else if ((state == IDLE) && start && !cache_hit) begin
      cache_vld <= 1'b0;
      cache_key <= key_in;
    end else if ((state == EXPAND) && (ctr == 4'(NR))) begin
      cache_vld  <= 1'b1;
      cache_rk10 <= fwd_rk;
    end
  end
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule using the FIPS-197 AES-128 key expansion vectors.
// Each scenario task drives stimulus and checks its own results; a summary line ends the run.
// Outputs are sampled 1 time unit after the rising edge, inputs change at the same point.
module tb_inv_key_schedule;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         busy;
  logic         done;

  int errors;
  int checks;

  logic [127:0] exp_fips [0:10];
  logic [127:0] got_rk   [0:10];
  logic [3:0]   got_rd   [0:10];
  int           got_n;
  int           stab_err;
  int           overlap;
  int           done_cnt;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
`ifdef KS_KEY_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 10;
`endif

  inv_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present key with start for one edge (edge E); returns 1 unit after E
  task automatic kick(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Count edges after E until rk_valid rises; optionally pulses start meanwhile
  task automatic wait_valid(input bit poke, output int cyc);
    cyc = 0;
    while (!rk_valid && cyc < 40) begin
      start = poke && (cyc % 2 == 1);
      if (poke) key_in = 128'h0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  // Accept keys until done, recording each transferred key and watching stall stability
  task automatic drain(input bit rnd, input bit poke);
    logic [127:0] prev_rk;
    logic [3:0]   prev_rd;
    bit           stalled;
    bit           r;
    bit           seen_done;
    got_n = 0; stab_err = 0; overlap = 0; done_cnt = 0;
    stalled = 1'b0; seen_done = 1'b0; prev_rk = '0; prev_rd = '0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      if (done) begin
        done_cnt++;
        seen_done = 1'b1;
        if (rk_valid) overlap++;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rk_valid) begin
        if (stalled && (rk !== prev_rk || rk_round !== prev_rd)) stab_err++;
        if (r) begin
          if (got_n < 11) begin
            got_rk[got_n] = rk;
            got_rd[got_n] = rk_round;
          end
          got_n++;
        end
        stalled = !r;
        prev_rk = rk;
        prev_rd = rk_round;
      end else begin
        stalled = 1'b0;
      end
      rk_ready = r;
      start = poke && (c % 2 == 1) && (got_n < 11) && !seen_done;
      if (poke) key_in = 128'h0;
      if (!seen_done) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    if (done) done_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
    #1;
    checks++;
    if ({rk, rk_round, rk_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rk=%h round=%0d valid=%b busy=%b done=%b, want all 0",
               rk, rk_round, rk_valid, busy, done);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rk, rk_round, rk_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got rk=%h round=%0d valid=%b busy=%b done=%b, want all 0",
               rk, rk_round, rk_valid, busy, done);
    end
  endtask

  task automatic test_fips_sequence();
    int lat;
    rk_ready = 1'b1;
    kick(FIPS_KEY);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fips_busy_expand: got %b want 1", busy);
    end
    wait_valid(1'b0, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL fips_latency: got %0d want 10", lat);
    end
    drain(1'b0, 1'b0);
    checks++;
    if (got_n !== 11) begin
      errors++;
      $display("FAIL fips_count: got %0d want 11", got_n);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_fips[10-i] || got_rd[i] !== 4'(10-i)) begin
        errors++;
        $display("FAIL fips_key[%0d]: got round %0d %h want round %0d %h",
                 i, got_rd[i], got_rk[i], 10-i, exp_fips[10-i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || overlap !== 0) begin
      errors++;
      $display("FAIL fips_done_pulse: got pulses=%0d overlap=%0d want 1 and 0", done_cnt, overlap);
    end
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_idle_after: got busy=%b valid=%b want 0 0", busy, rk_valid);
    end
  endtask

  task automatic test_random_ready();
    int lat;
    kick(FIPS_KEY);
    wait_valid(1'b0, lat);
    drain(1'b1, 1'b0);
    checks++;
    if (got_n !== 11 || stab_err !== 0) begin
      errors++;
      $display("FAIL stall_count_stable: got count=%0d unstable=%0d want 11 and 0", got_n, stab_err);
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_fips[10-i] || got_rd[i] !== 4'(10-i)) begin
        errors++;
        $display("FAIL stall_key[%0d]: got round %0d %h want round %0d %h",
                 i, got_rd[i], got_rk[i], 10-i, exp_fips[10-i]);
      end
    end
    checks++;
    if (done_cnt !== 1 || overlap !== 0) begin
      errors++;
      $display("FAIL stall_done_pulse: got pulses=%0d overlap=%0d want 1 and 0", done_cnt, overlap);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    rk_ready = 1'b1;
    kick(FIPS_KEY);
    wait_valid(1'b1, lat);
    drain(1'b0, 1'b1);
    checks++;
    if (got_n !== 11 || done_cnt !== 1) begin
      errors++;
      $display("FAIL ignore_count: got count=%0d pulses=%0d want 11 and 1", got_n, done_cnt);
    end
    for (int i = 0; i < 11; i += 5) begin
      checks++;
      if (got_rk[i] !== exp_fips[10-i] || got_rd[i] !== 4'(10-i)) begin
        errors++;
        $display("FAIL ignore_key[%0d]: got round %0d %h want round %0d %h",
                 i, got_rd[i], got_rk[i], 10-i, exp_fips[10-i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle_after: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int n;
    rk_ready = 1'b1;
    kick(FIPS_KEY);
    wait_valid(1'b0, lat);
    n = 0;
    while (!(rk_valid && rk_round == 4'd5) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rk !== exp_fips[5]) begin
      errors++;
      $display("FAIL abort_round5_key: got %h want %h", rk, exp_fips[5]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rk, rk_round, rk_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got rk=%h round=%0d valid=%b busy=%b done=%b, want all 0",
               rk, rk_round, rk_valid, busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got %b want 0", done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    kick(FIPS_KEY);
    wait_valid(1'b0, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL abort_restart_latency: got %0d want 10", lat);
    end
    drain(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_fips[10-i]) begin
        errors++;
        $display("FAIL abort_restart_key[%0d]: got %h want %h", i, got_rk[i], exp_fips[10-i]);
      end
    end
  endtask

  task automatic test_zero_key();
    int lat;
    rk_ready = 1'b1;
    kick(128'h0);
    wait_valid(1'b0, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL zero_latency: got %0d want 10", lat);
    end
    checks++;
    if (rk !== ZERO_R10 || rk_round !== 4'd10) begin
      errors++;
      $display("FAIL zero_round10: got round %0d %h want round 10 %h", rk_round, rk, ZERO_R10);
    end
    drain(1'b0, 1'b0);
    checks++;
    if (got_n !== 11 || got_rk[10] !== 128'h0 || got_rd[10] !== 4'd0) begin
      errors++;
      $display("FAIL zero_round0: got count=%0d round %0d %h want 11, round 0, all-zero",
               got_n, got_rd[10], got_rk[10]);
    end
  endtask

  task automatic test_key_cache();
    int lat;
    rk_ready = 1'b1;
    kick(FIPS_KEY);
    wait_valid(1'b0, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL cache_miss_latency: got %0d want 10", lat);
    end
    drain(1'b0, 1'b0);
    kick(FIPS_KEY);
    wait_valid(1'b0, lat);
    checks++;
    if (lat !== HIT_LAT) begin
      errors++;
      $display("FAIL cache_repeat_latency: got %0d want %0d", lat, HIT_LAT);
    end
    drain(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (got_rk[i] !== exp_fips[10-i] || got_rd[i] !== 4'(10-i)) begin
        errors++;
        $display("FAIL cache_repeat_key[%0d]: got round %0d %h want round %0d %h",
                 i, got_rd[i], got_rk[i], 10-i, exp_fips[10-i]);
      end
    end
    kick(128'h0);
    wait_valid(1'b0, lat);
    checks++;
    if (lat !== 10 || rk !== ZERO_R10) begin
      errors++;
      $display("FAIL cache_other_key: got latency %0d rk %h want 10 and %h", lat, rk, ZERO_R10);
    end
    drain(1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips_sequence();
    test_random_ready();
    test_start_ignored();
    test_reset_abort();
    test_zero_key();
    test_key_cache();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
